// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// The select encoding matches the mux convention: 0 steers requester A, 1 steers requester B.
package mips_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mips_mem_port_arbiter_mux2.sv
// Plain 2:1 steering mux: sel = 0 passes a, sel = 1 passes b.
module mips_mem_port_arbiter_mux2 #(
   parameter int WIDTH = 32
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/mips_mem_port_arbiter.sv
// Two-way round-robin arbiter for the shared memory port (A = fetch, B = LSU).
// Runs one transaction at a time, with a req/ack handshake and a BUSY watchdog.
module mips_mem_port_arbiter
   import mips_arb_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             REQ_A,
   input  logic [AW-1:0]    ADDR_A,
   input  logic [WIDTH-1:0] WDATA_A,
   input  logic             WE_A,
   input  logic             REQ_B,
   input  logic [AW-1:0]    ADDR_B,
   input  logic [WIDTH-1:0] WDATA_B,
   input  logic             WE_B,
   output logic             DONE_A,
   output logic             DONE_B,
   output logic             ERR,
   output logic [WIDTH-1:0] RDATA,
   output logic             Sel,
   output logic             MEM_REQ,
   output logic [AW-1:0]    MEM_ADDR,
   output logic [WIDTH-1:0] MEM_WDATA,
   output logic             MEM_WE,
   input  logic             MEM_ACK,
   input  logic [WIDTH-1:0] MEM_RDATA
);

   localparam int             CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   arb_state_t    state;
   logic [CW-1:0] cnt;
   logic          last_grant;
   logic          elig_a, elig_b, win;
   logic          sel_we;

   // A requester is blocked in its own done cycle so the other side gets a turn.
   assign elig_a = REQ_A & ~DONE_A;
   assign elig_b = REQ_B & ~DONE_B;

   always_comb begin
      win = SEL_A;
      if (elig_a && elig_b) win = (last_grant == SEL_A) ? SEL_B : SEL_A;
      else if (elig_b)      win = SEL_B;
   end

   mips_mem_port_arbiter_mux2 #(.WIDTH(AW)) u_addr_mux (
      .sel (Sel),
      .a   (ADDR_A),
      .b   (ADDR_B),
      .y   (MEM_ADDR)
   );

   mips_mem_port_arbiter_mux2 #(.WIDTH(WIDTH + 1)) u_data_mux (
      .sel (Sel),
      .a   ({WE_A, WDATA_A}),
      .b   ({WE_B, WDATA_B}),
      .y   ({sel_we, MEM_WDATA})
   );

   assign MEM_WE = sel_we & MEM_REQ;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state      <= IDLE;
         Sel        <= SEL_A;
         MEM_REQ    <= 1'b0;
         DONE_A     <= 1'b0;
         DONE_B     <= 1'b0;
         ERR        <= 1'b0;
         RDATA      <= '0;
         cnt        <= '0;
         last_grant <= SEL_B;
      end else begin
         DONE_A <= 1'b0;
         DONE_B <= 1'b0;
         ERR    <= 1'b0;
         case (state)
            IDLE: begin
               if (elig_a || elig_b) begin
                  Sel     <= win;
                  MEM_REQ <= 1'b1;
                  cnt     <= '0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               // ACK takes priority over an expiring watchdog in the same cycle.
               if (MEM_ACK || cnt == CNT_LAST) begin
                  DONE_A     <= (Sel == SEL_A);
                  DONE_B     <= (Sel == SEL_B);
                  ERR        <= ~MEM_ACK;
                  if (MEM_ACK) RDATA <= MEM_RDATA;
                  MEM_REQ    <= 1'b0;
                  last_grant <= Sel;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mem_port_arbiter.sv
// Self-checking bench: directed scenarios then randomized traffic against a transaction-level model.
module tb_mips_mem_port_arbiter;

   localparam int W  = 32;
   localparam int AW = 32;
   localparam int TO = 4;

   logic          CLK, RST_n;
   logic          REQ_A, WE_A, REQ_B, WE_B;
   logic [AW-1:0] ADDR_A, ADDR_B;
   logic [W-1:0]  WDATA_A, WDATA_B;
   logic          DONE_A, DONE_B, ERR, Sel, MEM_REQ, MEM_WE, MEM_ACK;
   logic [W-1:0]  RDATA, MEM_WDATA, MEM_RDATA;
   logic [AW-1:0] MEM_ADDR;

   mips_mem_port_arbiter #(.WIDTH(W), .AW(AW), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST_n(RST_n),
      .REQ_A(REQ_A), .ADDR_A(ADDR_A), .WDATA_A(WDATA_A), .WE_A(WE_A),
      .REQ_B(REQ_B), .ADDR_B(ADDR_B), .WDATA_B(WDATA_B), .WE_B(WE_B),
      .DONE_A(DONE_A), .DONE_B(DONE_B), .ERR(ERR), .RDATA(RDATA), .Sel(Sel),
      .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE),
      .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   // Reference model: who holds the port, how long it has waited, and the pulses due next.
   bit          m_busy, m_owner, m_last, m_da, m_db, m_err;
   int          m_wait;
   logic [W-1:0] m_rdata;

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_last = 1; m_da = 0; m_db = 0; m_err = 0;
      m_wait = 0; m_rdata = '0;
   endtask

   task automatic model_edge();
      bit ea, eb, fin;
      ea  = REQ_A && !m_da;
      eb  = REQ_B && !m_db;
      fin = 0;
      m_da = 0; m_db = 0; m_err = 0;
      if (m_busy) begin
         if (MEM_ACK) begin
            fin = 1; m_rdata = MEM_RDATA;
         end else if (m_wait == TO - 1) begin
            fin = 1; m_err = 1;
         end else begin
            m_wait++;
         end
         if (fin) begin
            if (m_owner) m_db = 1; else m_da = 1;
            m_busy = 0; m_last = m_owner;
         end
      end else if (ea || eb) begin
         m_owner = (ea && eb) ? !m_last : eb;
         m_busy  = 1;
         m_wait  = 0;
      end
   endtask

   task automatic check_all();
      chk("mem_req", 64'(MEM_REQ), 64'(m_busy));
      chk("sel",     64'(Sel),     64'(m_owner));
      chk("done_a",  64'(DONE_A),  64'(m_da));
      chk("done_b",  64'(DONE_B),  64'(m_db));
      chk("err",     64'(ERR),     64'(m_err));
      chk("rdata",   64'(RDATA),   64'(m_rdata));
      chk("mem_addr",  64'(MEM_ADDR),  64'(m_owner ? ADDR_B : ADDR_A));
      chk("mem_wdata", 64'(MEM_WDATA), 64'(m_owner ? WDATA_B : WDATA_A));
      chk("mem_we",    64'(MEM_WE),    64'(m_busy && (m_owner ? WE_B : WE_A)));
   endtask

   task automatic step();
      model_edge();
      @(posedge CLK);
      #1;
      check_all();
   endtask

   task automatic hard_reset();
      RST_n = 1'b0;
      model_reset();
      #1;
      chk("rst_mem_req", 64'(MEM_REQ), 64'd0);
      chk("rst_sel",     64'(Sel),     64'd0);
      chk("rst_done",    64'({DONE_A, DONE_B}), 64'd0);
      @(posedge CLK);
      #1;
      check_all();
      RST_n = 1'b1;
   endtask

   int g;
   bit pend_a, pend_b;

   initial begin
      RST_n = 1'b0;
      {REQ_A, WE_A, REQ_B, WE_B, MEM_ACK} = '0;
      ADDR_A = '0; ADDR_B = '0; WDATA_A = '0; WDATA_B = '0; MEM_RDATA = '0;
      @(posedge CLK);
      hard_reset();
      chk("rst_rdata", 64'(RDATA), 64'd0);
      chk("rst_err",   64'(ERR),   64'd0);

      // single A read
      REQ_A = 1; ADDR_A = 32'h100; WE_A = 0; WDATA_A = 32'h0;
      step();
      chk("a_rd_addr", 64'(MEM_ADDR), 64'h100);
      chk("a_rd_we",   64'(MEM_WE),   64'd0);
      MEM_ACK = 1; MEM_RDATA = 32'hDEADBEEF;
      step();
      chk("a_rd_done",  64'(DONE_A), 64'd1);
      chk("a_rd_rdata", 64'(RDATA),  64'hDEADBEEF);
      chk("a_rd_err",   64'(ERR),    64'd0);
      REQ_A = 0; MEM_ACK = 0;
      step();

      // round-robin with both held
      hard_reset();
      REQ_A = 1; ADDR_A = 32'h10; REQ_B = 1; ADDR_B = 32'h20; WDATA_B = 32'h7; MEM_ACK = 1;
      g = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("rr_overlap", 64'(DONE_A & DONE_B), 64'd0);
         if (MEM_REQ) begin
            chk("rr_order", 64'(Sel), 64'(g % 2));
            g++;
         end
      end
      chk("rr_grants", 64'(g), 64'd4);
      REQ_A = 0; REQ_B = 0; MEM_ACK = 0;
      step();

      // B write, ACK on the third BUSY cycle
      REQ_B = 1; WE_B = 1; ADDR_B = 32'h2000; WDATA_B = 32'h55AA55AA;
      step();
      for (int i = 0; i < 2; i++) begin
         chk("b_wr_we",    64'(MEM_WE),    64'd1);
         chk("b_wr_wdata", 64'(MEM_WDATA), 64'h55AA55AA);
         step();
      end
      chk("b_wr_we3", 64'(MEM_WE), 64'd1);
      MEM_ACK = 1;
      step();
      chk("b_wr_done", 64'(DONE_B), 64'd1);
      chk("b_wr_err",  64'(ERR),    64'd0);
      REQ_B = 0; WE_B = 0; MEM_ACK = 0;
      step();

      // timeout on A while B waits, then B acked exactly at the watchdog limit
      REQ_A = 1; ADDR_A = 32'h300; WE_A = 0; REQ_B = 1; ADDR_B = 32'h400;
      step();
      chk("to_grant_a", 64'(Sel), 64'd0);
      for (int i = 0; i < TO; i++) begin
         step();
         chk("to_done_a", 64'(DONE_A), 64'(i == TO - 1));
      end
      chk("to_err",     64'(ERR),     64'd1);
      chk("to_mem_req", 64'(MEM_REQ), 64'd0);
      chk("to_rdata",   64'(RDATA),   64'hDEADBEEF);
      REQ_A = 0;
      step();
      chk("to_grant_b", 64'(Sel),     64'd1);
      chk("to_b_req",   64'(MEM_REQ), 64'd1);
      for (int i = 0; i < TO - 1; i++) step();
      MEM_ACK = 1; MEM_RDATA = 32'h12345678;
      step();
      chk("edge_done_b", 64'(DONE_B), 64'd1);
      chk("edge_err",    64'(ERR),    64'd0);
      chk("edge_rdata",  64'(RDATA),  64'h12345678);
      REQ_B = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stray_ack", 64'({DONE_A, DONE_B}), 64'd0);
      end
      MEM_ACK = 0;

      // reset while BUSY
      REQ_A = 1; ADDR_A = 32'h500;
      step();
      step();
      hard_reset();
      step();
      chk("rst_regrant_sel", 64'(Sel),     64'd0);
      chk("rst_regrant_req", 64'(MEM_REQ), 64'd1);
      MEM_ACK = 1;
      step();
      REQ_A = 0; MEM_ACK = 0;
      step();

      // randomized traffic
      pend_a = 0; pend_b = 0;
      for (int c = 0; c < 3000; c++) begin
         if (m_da) pend_a = 0;
         if (m_db) pend_b = 0;
         if (!pend_a) begin
            if ($urandom_range(2) == 0) begin
               pend_a = 1; REQ_A = 1; ADDR_A = $urandom; WDATA_A = $urandom; WE_A = $urandom_range(1);
            end else REQ_A = 0;
         end else if (m_busy && !m_owner && $urandom_range(19) == 0) REQ_A = 0;
         if (!pend_b) begin
            if ($urandom_range(2) == 0) begin
               pend_b = 1; REQ_B = 1; ADDR_B = $urandom; WDATA_B = $urandom; WE_B = $urandom_range(1);
            end else REQ_B = 0;
         end else if (m_busy && m_owner && $urandom_range(19) == 0) REQ_B = 0;
         MEM_ACK   = m_busy ? ($urandom_range(9) < 3) : ($urandom_range(9) == 0);
         MEM_RDATA = $urandom;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mips_mem_port_arbiter.md
Name: mips_mem_port_arbiter

Overview:
- Shares one memory port between two requesters: A = instruction fetch, B = load/store unit.
- Chooses a requester, drives the select line of the existing WIDTH-parameterised 2:1 mux that steers address, write data and write enable, and sequences one transaction at a time.
- Uses a req/ack handshake on the memory side and a watchdog timeout.
- Sits between the fetch/LSU stages and the unified memory interface.

Parameters:
WIDTH, 32, data bus width (rdata, wdata)
AW, 32, address width
TIMEOUT, 16, maximum BUSY cycles waiting for MEM_ACK before abort; legal range 2..255

Ports:
CLK  in  1  system clock, rising edge
RST_n  in  1  asynchronous, active-low reset
REQ_A  in  1  requester A transaction request
ADDR_A  in  AW  requester A address
WDATA_A  in  WIDTH  requester A write data
WE_A  in  1  requester A write enable
REQ_B  in  1  requester B transaction request
ADDR_B  in  AW  requester B address
WDATA_B  in  WIDTH  requester B write data
WE_B  in  1  requester B write enable
DONE_A  out  1  one-cycle completion pulse to A
DONE_B  out  1  one-cycle completion pulse to B
ERR  out  1  valid with a DONE pulse: 1 = timed out, RDATA invalid
RDATA  out  WIDTH  read data, valid with a DONE pulse
Sel  out  1  mux select: 0 = A, 1 = B
MEM_REQ  out  1  memory transaction request
MEM_ADDR  out  AW  muxed address
MEM_WDATA  out  WIDTH  muxed write data
MEM_WE  out  1  muxed write enable, gated by MEM_REQ
MEM_ACK  in  1  memory completion; read data valid in the same cycle
MEM_RDATA  in  WIDTH  memory read data

Behaviour:
- Clock and reset: single clock CLK; asynchronous, active-low reset RST_n.
- Reset values:
  - state = IDLE; Sel = 0; MEM_REQ = 0.
  - DONE_A = 0, DONE_B = 0, ERR = 0, RDATA = 0.
  - wait counter = 0; last_grant = B, so A wins the first conflict.
  - Reset mid-transaction drops MEM_REQ immediately and emits no DONE.
- States: IDLE, BUSY.
- Requester contract: hold REQ_x and its fields stable from assertion until the DONE_x pulse.
- Eligibility in IDLE: REQ_x is eligible only when DONE_x is low, so a requester cannot be re-granted in its own done cycle.
- IDLE, exactly one requester eligible: grant it.
- IDLE, both eligible: grant the requester that is not last_grant (round-robin).
- IDLE, none eligible: stay in IDLE.
- Grant edge:
  - Sel is registered to the winner.
  - MEM_REQ <= 1; counter <= 0; state <= BUSY.
- BUSY datapath:
  - MEM_ADDR and MEM_WDATA come through the 2:1 mux on the live requester fields selected by Sel.
  - MEM_WE = selected WE and MEM_REQ.
  - Sel must not change while in BUSY.
- BUSY with MEM_ACK = 1:
  - next edge: DONE_Sel <= 1, ERR <= 0, RDATA <= MEM_RDATA.
  - MEM_REQ <= 0; last_grant <= Sel; state <= IDLE.
- BUSY with MEM_ACK = 0 and counter == TIMEOUT-1:
  - next edge: DONE_Sel <= 1, ERR <= 1, RDATA holds its previous value.
  - MEM_REQ <= 0; last_grant <= Sel; state <= IDLE.
- BUSY otherwise: counter increments.
- ACK and timeout in the same cycle: the ACK wins and ERR = 0.
- Pulse outputs:
  - DONE_A and DONE_B last exactly one cycle and are never high together.
  - ERR is meaningful only while a DONE is high and is cleared the next cycle.
- Stray ACK: MEM_ACK while in IDLE is ignored.
- Dropped request: if REQ_x deasserts during BUSY, the transaction still completes and still pulses DONE_x.
- Latency:
  - request sampled at edge k; MEM_REQ high after edge k.
  - with MEM_ACK in the first BUSY cycle, DONE is high after edge k+1.
  - best-case request-to-DONE is 2 cycles; back-to-back grants are 1 idle cycle apart.
- Counter width: ceil(log2(TIMEOUT)) bits; no wrap is possible.

Decomposition:
- Shared package mips_arb_pkg:
  - state enum arb_state_t {IDLE, BUSY}.
  - constants SEL_A = 1'b0 and SEL_B = 1'b1.
- Sub-module: reuse the existing 2:1 mux module for the steering.
  - Two instances: one at WIDTH = AW for the address, one at WIDTH = WIDTH+1 for {WE, WDATA}.
  - The arbiter owns only control, the counter, RDATA and the DONE/ERR registers.

Test Plan:
- Reset while BUSY (REQ_A high, no ACK, RST_n low for 1 cycle) -> MEM_REQ = 0, Sel = 0, no DONE; after release A is re-granted.
- Single A read:
  - stimulus: REQ_A = 1, ADDR_A = 0x100, WE_A = 0; MEM_ACK high in the first BUSY cycle with MEM_RDATA = 0xDEADBEEF.
  - response: Sel = 0, MEM_ADDR = 0x100, MEM_WE = 0; DONE_A pulses 2 cycles after REQ_A; RDATA = 0xDEADBEEF, ERR = 0.
- Simultaneous REQ_A and REQ_B, both held, ACK after 1 BUSY cycle each:
  - grant order A, B, A, B; Sel toggles.
  - DONE_A and DONE_B alternate and never overlap.
- B write:
  - stimulus: WE_B = 1, ADDR_B = 0x2000, WDATA_B = 0x55AA55AA, ACK on the 3rd BUSY cycle.
  - response: MEM_WE = 1 and MEM_WDATA = 0x55AA55AA throughout BUSY; DONE_B pulses one cycle after the ACK; ERR = 0.
- Timeout, TIMEOUT = 4, MEM_ACK never asserted:
  - DONE_A with ERR = 1 exactly 4 cycles after the grant edge.
  - MEM_REQ drops; a waiting REQ_B is granted on the next edge.
- ACK coincident with counter == TIMEOUT-1 -> DONE with ERR = 0 and RDATA = MEM_RDATA; a stray MEM_ACK in IDLE produces no DONE.
